// File: rtl/seven_segment_word_capture.sv
// Receive side of a multiplexed 4-digit 7-segment display: settles and decodes each
// scanned digit, assembles a 4-character frame and hands it over on valid/ready.
module seven_segment_word_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  abcdefgh,
  input  logic [3:0]  digit,
  output logic [19:0] frame_codes,
  output logic [3:0]  frame_dots,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        frame_changed,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_ZERO = IW'(0);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  function automatic logic f_one_low(input logic [3:0] d);
    logic r;
    case (d)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] f_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b1111001: r = 5'h01;  // "I" drawn on the left segments
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b1100000: r = 5'h0B;
      7'b0110001: r = 5'h0C;
      7'b1000010: r = 5'h0D;
      7'b0110000: r = 5'h0E;
      7'b0111000: r = 5'h0F;
      7'b1111111: r = 5'h10;
      7'b1101000: r = 5'h11;
      7'b0011000: r = 5'h12;
      7'b1001000: r = 5'h13;
      7'b1110001: r = 5'h14;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [7:0]    r_seg_meta, r_seg_sync, r_lat_seg;
  logic [3:0]    r_dig_meta, r_dig_sync, r_lat_dig;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_lat_load, w_capture, w_strobe_ok, w_same;
  logic [4:0]    r_slot_code [4];
  logic [3:0]    r_slot_dot;
  logic [3:0]    r_filled, w_filled_nxt, w_slot_onehot;
  logic [IW-1:0] r_idle, w_idle_nxt;
  logic          r_stale, w_stale_nxt, w_stale_rise;
  logic [19:0]   r_frame_codes;
  logic [3:0]    r_frame_dots;
  logic          r_valid, r_changed, r_have_last;
  logic [23:0]   r_last, w_new_frame, w_ref_frame;
  logic          w_accept, w_xfer, w_have_ref;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_meta <= 8'hFF;
      r_seg_sync <= 8'hFF;
      r_dig_meta <= 4'hF;
      r_dig_sync <= 4'hF;
    end else begin
      r_seg_meta <= abcdefgh;
      r_seg_sync <= r_seg_meta;
      r_dig_meta <= digit;
      r_dig_sync <= r_dig_meta;
    end
  end

  assign w_strobe_ok   = f_one_low(r_dig_sync);
  assign w_same        = (r_dig_sync == r_lat_dig) && (r_seg_sync == r_lat_seg);
  assign w_slot_onehot = ~r_lat_dig;

  always_comb begin
    w_state_nxt = r_state;
    w_lat_load  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_strobe_ok) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SETTLE;
          w_lat_load  = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end
        S_SETTLE: begin
          if (!w_same) begin
            w_lat_load = 1'b1;
            w_cnt_nxt  = CNT_ONE;
          end else if (r_cnt == CNT_LAST) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HELD;
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        S_HELD: begin
          if (w_same) begin
            w_state_nxt = S_HELD;
          end else begin
            w_state_nxt = S_SETTLE;
            w_lat_load  = 1'b1;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= CNT_ZERO;
      r_lat_dig <= 4'hF;
      r_lat_seg <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_lat_load) begin
        r_lat_dig <= r_dig_sync;
        r_lat_seg <= r_seg_sync;
      end
    end
  end

  // In the capture cycle the synchronized pattern equals the latched one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_slot_code[i] <= 5'h00;
      r_slot_dot <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_capture && w_slot_onehot[i]) begin
          r_slot_code[i] <= f_decode(r_lat_seg[7:1]);
          r_slot_dot[i]  <= ~r_lat_seg[0];
        end
      end
    end
  end

  always_comb begin
    if (w_capture) begin
      w_idle_nxt = IDLE_ZERO;
    end else if (r_idle == IDLE_MAX) begin
      w_idle_nxt = r_idle;
    end else begin
      w_idle_nxt = r_idle + IDLE_ONE;
    end
  end

  assign w_stale_nxt  = (w_idle_nxt == IDLE_MAX);
  assign w_stale_rise = w_stale_nxt & ~r_stale;
  assign w_accept     = r_valid & frame_ready;
  assign w_xfer       = (r_filled == 4'hF) & (~r_valid | frame_ready);
  assign w_new_frame  = {r_slot_code[3], r_slot_code[2], r_slot_code[1], r_slot_code[0], r_slot_dot};
  assign w_ref_frame  = w_accept ? {r_frame_codes, r_frame_dots} : r_last;
  assign w_have_ref   = r_have_last | w_accept;

  // A capture landing in the transfer cycle starts the next frame.
  always_comb begin
    if (w_xfer || w_stale_rise) begin
      w_filled_nxt = 4'h0;
    end else begin
      w_filled_nxt = r_filled;
    end
    if (w_capture) begin
      w_filled_nxt = w_filled_nxt | w_slot_onehot;
    end else begin
      w_filled_nxt = w_filled_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle   <= IDLE_ZERO;
      r_stale  <= 1'b0;
      r_filled <= 4'h0;
    end else begin
      r_idle   <= w_idle_nxt;
      r_stale  <= w_stale_nxt;
      r_filled <= w_filled_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_codes <= 20'h00000;
      r_frame_dots  <= 4'h0;
      r_valid       <= 1'b0;
      r_changed     <= 1'b0;
      r_last        <= 24'h000000;
      r_have_last   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_frame_codes <= w_new_frame[23:4];
        r_frame_dots  <= w_new_frame[3:0];
        r_valid       <= 1'b1;
        r_changed     <= ~w_have_ref | (w_new_frame != w_ref_frame);
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (w_accept) begin
        r_last      <= {r_frame_codes, r_frame_dots};
        r_have_last <= 1'b1;
      end
    end
  end

  assign frame_codes   = r_frame_codes;
  assign frame_dots    = r_frame_dots;
  assign frame_valid   = r_valid;
  assign frame_changed = r_changed;
  assign stale         = r_stale;

endmodule

// File: tb/tb_seven_segment_word_capture.sv
// Directed bench for seven_segment_word_capture (STABLE_CYCLES=16, TIMEOUT_CYCLES=256).
module tb_seven_segment_word_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [19:0] frame_codes;
  logic [3:0]  frame_dots;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_changed;
  logic        stale;

  int checks = 0;
  int errors = 0;

  seven_segment_word_capture #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .reset_n(reset_n), .abcdefgh(abcdefgh), .digit(digit),
    .frame_codes(frame_codes), .frame_dots(frame_dots), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_changed(frame_changed), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] d, input logic [7:0] s);
    digit    = d;
    abcdefgh = s;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; frame_ready = 1'b0; drive(4'b1111, 8'hFF);
    tick(3);
    checks++;
    if ({frame_codes, frame_dots, frame_valid, frame_changed, stale} !== 27'h0) begin
      errors++;
      $display("FAIL reset_hold: codes=%h dots=%b v=%b ch=%b st=%b, expected all zero", frame_codes, frame_dots, frame_valid, frame_changed, stale);
    end
    reset_n = 1'b1;
    tick(2);
    checks++;
    if ({frame_codes, frame_dots, frame_valid, frame_changed, stale} !== 27'h0) begin
      errors++;
      $display("FAIL reset_release: codes=%h dots=%b v=%b ch=%b st=%b, expected all zero", frame_codes, frame_dots, frame_valid, frame_changed, stale);
    end
  endtask

  task automatic test_scan(input logic exp_changed);
    logic [19:0] exp;
    exp = {5'h0C, 5'h11, 5'h01, 5'h12};
    frame_ready = 1'b1;
    drive(4'b0111, 8'h63); tick(64);
    drive(4'b1011, 8'hD1); tick(64);
    drive(4'b1101, 8'hF3); tick(64);
    drive(4'b1110, 8'h31); tick(18);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL scan_latency_early: valid=%b expected 0", frame_valid);
    end
    tick(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp || frame_dots !== 4'h0 || frame_changed !== exp_changed) begin
      errors++;
      $display("FAIL scan_frame: v=%b codes=%h dots=%b ch=%b, expected 1 %h 0000 %b", frame_valid, frame_codes, frame_dots, frame_changed, exp, exp_changed);
    end
    tick(1);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL scan_accepted: valid=%b expected 0", frame_valid);
    end
    tick(44);
  endtask

  task automatic test_no_capture;
    logic seen;
    frame_ready = 1'b1;
    drive(4'b1011, 8'hD1); tick(64);
    drive(4'b1101, 8'hF3); tick(64);
    drive(4'b1110, 8'h31); tick(64);
    for (int i = 0; i < 8; i++) begin
      seen = 1'b0;
      drive(4'b0111, (i % 2 == 1) ? 8'h62 : 8'h63);
      for (int j = 0; j < 15; j++) begin
        tick(1);
        if (frame_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++; $display("FAIL short_hold_%0d: frame_valid seen=%b expected 0", i, seen);
      end
    end
    drive(4'b0111, 8'h63); tick(18);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL short_hold_settle: valid=%b expected 0", frame_valid);
    end
    tick(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== {5'h0C, 5'h11, 5'h01, 5'h12} || frame_dots !== 4'h0 || frame_changed !== 1'b0) begin
      errors++;
      $display("FAIL short_hold_frame: v=%b codes=%h dots=%b ch=%b, expected 1 %h 0000 0", frame_valid, frame_codes, frame_dots, frame_changed, {5'h0C, 5'h11, 5'h01, 5'h12});
    end
    tick(45);
  endtask

  task automatic test_backpressure;
    logic [19:0] exp_a, exp_b;
    exp_a = {5'h00, 5'h01, 5'h02, 5'h03};
    exp_b = {5'h13, 5'h14, 5'h0A, 5'h10};
    frame_ready = 1'b0;
    drive(4'b0111, 8'h02); tick(64);
    drive(4'b1011, 8'h9F); tick(64);
    drive(4'b1101, 8'h25); tick(64);
    drive(4'b1110, 8'h0C); tick(19);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp_a || frame_dots !== 4'b1001 || frame_changed !== 1'b1) begin
      errors++;
      $display("FAIL bp_frame_a: v=%b codes=%h dots=%b ch=%b, expected 1 %h 1001 1", frame_valid, frame_codes, frame_dots, frame_changed, exp_a);
    end
    tick(45);
    drive(4'b0111, 8'h91); tick(64);
    drive(4'b1011, 8'hE3); tick(64);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp_a || frame_dots !== 4'b1001) begin
      errors++;
      $display("FAIL bp_frozen_mid: v=%b codes=%h dots=%b, expected 1 %h 1001", frame_valid, frame_codes, frame_dots, exp_a);
    end
    drive(4'b1101, 8'h11); tick(64);
    drive(4'b1110, 8'hFE); tick(64);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp_a || frame_dots !== 4'b1001) begin
      errors++;
      $display("FAIL bp_frozen_end: v=%b codes=%h dots=%b, expected 1 %h 1001", frame_valid, frame_codes, frame_dots, exp_a);
    end
    frame_ready = 1'b1;
    tick(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp_b || frame_dots !== 4'b0001 || frame_changed !== 1'b1) begin
      errors++;
      $display("FAIL bp_frame_b: v=%b codes=%h dots=%b ch=%b, expected 1 %h 0001 1", frame_valid, frame_codes, frame_dots, frame_changed, exp_b);
    end
    tick(1);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL bp_b_accepted: valid=%b expected 0", frame_valid);
    end
  endtask

  task automatic test_invalid_strobe;
    logic        seen;
    logic [19:0] exp;
    exp = {5'h0B, 5'h0D, 5'h0E, 5'h1F};
    frame_ready = 1'b1;
    drive(4'b0111, 8'hC1); tick(64);
    drive(4'b1011, 8'h85); tick(64);
    drive(4'b1101, 8'h61); tick(64);
    seen = 1'b0;
    drive(4'b0011, 8'h02);
    for (int k = 0; k < 40; k++) begin tick(1); if (frame_valid) seen = 1'b1; end
    drive(4'b1111, 8'h02);
    for (int k = 0; k < 40; k++) begin tick(1); if (frame_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL invalid_strobe_ignored: frame_valid seen=%b expected 0", seen);
    end
    drive(4'b1110, 8'h7F); tick(19);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp || frame_dots !== 4'h0 || frame_changed !== 1'b1) begin
      errors++;
      $display("FAIL invalid_unknown_frame: v=%b codes=%h dots=%b ch=%b, expected 1 %h 0000 1", frame_valid, frame_codes, frame_dots, frame_changed, exp);
    end
    tick(45);
  endtask

  task automatic test_stale;
    logic        seen;
    logic [19:0] exp;
    exp = {5'h09, 5'h0F, 5'h06, 5'h07};
    frame_ready = 1'b1;
    drive(4'b0111, 8'h99); tick(64);
    drive(4'b1011, 8'h49); tick(18);
    drive(4'b1111, 8'hFF); tick(255);
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL stale_early: stale=%b expected 0", stale);
    end
    tick(1);
    checks++;
    if (stale !== 1'b1) begin
      errors++; $display("FAIL stale_assert: stale=%b expected 1", stale);
    end
    drive(4'b1101, 8'h41); tick(17);
    checks++;
    if (stale !== 1'b1) begin
      errors++; $display("FAIL stale_held: stale=%b expected 1", stale);
    end
    tick(1);
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL stale_clear: stale=%b expected 0", stale);
    end
    tick(46);
    seen = 1'b0;
    drive(4'b1110, 8'h1F);
    for (int k = 0; k < 64; k++) begin tick(1); if (frame_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL stale_discard: frame_valid seen=%b expected 0", seen);
    end
    drive(4'b0111, 8'h09); tick(64);
    drive(4'b1011, 8'h71); tick(19);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp || frame_dots !== 4'h0 || frame_changed !== 1'b1) begin
      errors++;
      $display("FAIL stale_next_frame: v=%b codes=%h dots=%b ch=%b, expected 1 %h 0000 1", frame_valid, frame_codes, frame_dots, frame_changed, exp);
    end
    tick(45);
  endtask

  task automatic test_reset_mid;
    logic        seen;
    logic [19:0] exp;
    exp = {5'h08, 5'h12, 5'h11, 5'h0D};
    frame_ready = 1'b1;
    drive(4'b0111, 8'h11); tick(64);
    drive(4'b1011, 8'hC1); tick(64);
    drive(4'b1101, 8'h63); tick(64);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({frame_codes, frame_dots, frame_valid, frame_changed, stale} !== 27'h0) begin
      errors++;
      $display("FAIL reset_mid_async: codes=%h dots=%b v=%b ch=%b st=%b, expected all zero", frame_codes, frame_dots, frame_valid, frame_changed, stale);
    end
    tick(2);
    reset_n = 1'b1;
    seen = 1'b0;
    drive(4'b1110, 8'h85);
    for (int k = 0; k < 64; k++) begin tick(1); if (frame_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_partial: frame_valid seen=%b expected 0", seen);
    end
    drive(4'b0111, 8'h01); tick(64);
    drive(4'b1011, 8'h31); tick(64);
    drive(4'b1101, 8'hD1); tick(18);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_early: valid=%b expected 0", frame_valid);
    end
    tick(1);
    checks++;
    if (frame_valid !== 1'b1 || frame_codes !== exp || frame_dots !== 4'h0 || frame_changed !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_frame: v=%b codes=%h dots=%b ch=%b, expected 1 %h 0000 1", frame_valid, frame_codes, frame_dots, frame_changed, exp);
    end
    tick(45);
  endtask

  initial begin
    test_reset();
    test_scan(1'b1);
    test_scan(1'b0);
    test_no_capture();
    test_backpressure();
    test_invalid_strobe();
    test_stale();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_word_capture.md
# seven_segment_word_capture

Receive-side companion to the multiplexed 4-digit 7-segment word driver. Samples the scanned segment bus and active-low digit strobes, waits for each digit's pattern to settle, decodes it back to a character code, and assembles one 4-character frame. Completed frames are handed over on a valid/ready interface. It sits on the board-to-board or self-check path, behind a second board's display connector or looped back from our own display outputs.

## Interface
- STABLE_CYCLES, default 16: consecutive identical synchronized samples required before a digit is captured; legal range is 2 or more.
- TIMEOUT_CYCLES, default 1048576: cycles without any capture before `stale` asserts.
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- abcdefgh  in  8  segment bus, bit 7 = a … bit 1 = g, bit 0 = h (dot); 0 = lit
- digit  in  4  digit strobes, active low; digit[3] is the leftmost position
- frame_codes  out  20  decoded characters; slot 3 at [19:15] … slot 0 at [4:0]
- frame_dots  out  4  dot state per slot, 1 = lit
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts the frame
- frame_changed  out  1  qualified by frame_valid; frame differs from the previously accepted frame
- stale  out  1  no capture for TIMEOUT_CYCLES cycles

## Operation
- `abcdefgh` and `digit` pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Strobe validity:
  - Valid means exactly one bit of `digit` is 0.
  - Zero or multiple low bits means no strobe. The capture FSM goes to IDLE and the settle counter clears.
- Capture FSM states: IDLE, SETTLE, HELD.
  - IDLE → SETTLE on a valid strobe. The strobe and pattern are latched and the counter is set to 1.
  - SETTLE, same strobe and pattern: counter increments. When the counter reaches STABLE_CYCLES, the slot is written and the FSM moves to HELD.
  - SETTLE, strobe or pattern changes to another valid value: re-latch and set the counter to 1.
  - HELD, same strobe and pattern: stay in HELD with no further writes.
  - HELD, pattern changes with the same strobe: go to SETTLE. A recapture overwrites the slot.
  - HELD, strobe changes: go to SETTLE for the new digit.
- Decode of bits 7:1 (abcdefg) into a 5-bit code:
  - 0x00 0000001; 0x01 1001111; 0x02 0010010; 0x03 0000110
  - 0x04 1001100; 0x05 0100100; 0x06 0100000; 0x07 0001111
  - 0x08 0000000; 0x09 0000100; 0x0A 0001000; 0x0B 1100000
  - 0x0C 0110001; 0x0D 1000010; 0x0E 0110000; 0x0F 0111000
  - 0x10 blank 1111111; 0x11 h 1101000; 0x12 P 0011000; 0x13 H 1001000; 0x14 L 1110001
  - Any other pattern decodes to 0x1F (unknown).
  - "I" decodes as 0x01.
- Dot: slot dot = ~bit 0.
- filled[3:0]: a capture sets the bit for its slot.
- Frame transfer:
  - Condition: filled == 4'b1111 AND (frame_valid == 0 OR frame_ready == 1).
  - Action: slot codes and dots are copied to the outputs, frame_valid is set, and filled is cleared.
  - A capture in the transfer cycle still sets its filled bit for the next frame. The copied slot value is the pre-capture value.
- Handshake:
  - frame_valid with frame_ready == 1 completes the handover. frame_valid drops the next cycle unless a new transfer occurs in the same cycle.
  - Outputs stay frozen while frame_valid == 1 and frame_ready == 0. Captures continue into the slots.
- frame_changed:
  - Compares {codes, dots} against the last accepted frame.
  - The first frame after reset has frame_changed == 1.
- Idle counter:
  - Clears on every capture. Otherwise it increments and saturates at TIMEOUT_CYCLES.
  - stale = 1 while saturated. filled clears when stale first asserts.
  - stale drops the cycle after the next capture.

## Timing
- Reset values:
  - frame_codes = 20'h0, frame_dots = 0, frame_valid = 0, frame_changed = 0, stale = 0.
  - filled = 0, FSM = IDLE, synchronizer flops = all 1s.
- Input-to-capture latency: a pattern stable at the pins from cycle t is written at the clock edge ending cycle t+1+STABLE_CYCLES. The slot is visible at t+2+STABLE_CYCLES.
- The fourth capture to frame_valid = 1 takes 1 cycle when the output buffer is free.
- A reset_n assertion mid-frame discards partial slots and any pending frame immediately.

## Test plan
- Scan C,h,I,P (0x63,0xD1,0xF3,0x31 on digits 0111,1011,1101,1110), 64 cycles each, frame_ready = 1 → frame_codes = {0x0C,0x11,0x01,0x12}, dots = 0, frame_changed = 1. The second identical frame has frame_changed = 0.
- Hold a pattern for STABLE_CYCLES-1 then toggle it, repeatedly → no capture, frame_valid stays 0.
- frame_ready = 0 across two complete scans → first frame frozen on outputs. Raising frame_ready delivers the second frame on the next cycle after acceptance.
- digit = 4'b0011 or 4'b1111 between scans → ignored, no slot written. Pattern 0x7F → code 0x1F.
- Stop strobing for TIMEOUT_CYCLES (parameter set to 256) → stale = 1 at cycle 256 and a partial frame is discarded. The next capture clears stale.
- Assert reset_n = 0 after 3 slots are captured → all outputs go to reset values immediately. After release, a full scan is needed for a frame.
